// File: rtl/ebus_ctl_pkg.sv
// Shared EBUS types: function codes, sequencer states and bus field widths.
package ebus_ctl_pkg;

  localparam int EBUS_DATA_W = 36;
  localparam int EBUS_CS_W   = 7;
  localparam int EBUS_FUNC_W = 3;
  localparam int EBUS_CNT_W  = 10;

  typedef enum logic [EBUS_FUNC_W-1:0] {
    CONO   = 3'd0,
    CONI   = 3'd1,
    DATAO  = 3'd2,
    DATAI  = 3'd3,
    PIserv = 3'd4,
    PIread = 3'd5,
    RSVD6  = 3'd6,
    RSVD7  = 3'd7
  } tEBUSfunc;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DEMAND,
    XWAIT
  } tEBUSstate;

  // Functions whose transfer returns data from the device onto the EBUS.
  function automatic logic is_read_func(tEBUSfunc f);
    return (f == CONI) || (f == DATAI) || (f == PIread);
  endfunction

endpackage

// File: rtl/ebus_prio.sv
// Lowest-index-wins request picker: one-hot of the lowest set bit plus a valid flag.
module ebus_prio #(
  parameter int N = 3
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] onehot_o,
  output logic         valid_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = req_i & (~req_i + N'(1));
  assign valid_o  = |req_i;

endmodule

// File: rtl/ebus_ctl.sv
// EBUS arbiter/sequencer: grant, CS/func setup, demand/transfer handshake with timeout.
// Optional multiple-driver detection is enabled by defining EBUS_CONFLICT_CHECK_EN.
module ebus_ctl
  import ebus_ctl_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int NDRV        = 13
) (
  input  logic                       clk,
  input  logic                       CROBAR,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*EBUS_FUNC_W-1:0] reqFunc,
  input  logic [NREQ*EBUS_CS_W-1:0]  reqCS,
  output logic [NREQ-1:0]            grant,
  output logic                       done,
  output logic                       timeout,
  output logic [EBUS_DATA_W-1:0]     rdData,
  output logic                       busy,
  output logic [EBUS_CS_W-1:0]       ebusCS,
  output logic [EBUS_FUNC_W-1:0]     ebusFunc,
  output logic                       ebusDemand,
  input  logic                       ebusXfer,
  input  logic [EBUS_DATA_W-1:0]     ebusData,
  input  logic [NDRV-1:0]            drivers,
  output logic                       conflict
);

  localparam logic [EBUS_CNT_W-1:0] SETUP_LAST = EBUS_CNT_W'(SETUP_CYC - 1);
  localparam logic [EBUS_CNT_W-1:0] TO_LAST    = EBUS_CNT_W'(TIMEOUT_CYC - 1);

  tEBUSstate              state_q;
  logic [EBUS_CNT_W-1:0]  cnt_q;
  logic [NREQ-1:0]        grant_q;
  logic                   done_q;
  logic                   timeout_q;
  logic [EBUS_DATA_W-1:0] rd_q;
  logic [EBUS_CS_W-1:0]   cs_q;
  tEBUSfunc               func_q;
  logic                   demand_q;

  logic [NREQ-1:0]        grant_d;
  logic                   pick_valid;
  logic [EBUS_CS_W-1:0]   cs_d;
  tEBUSfunc               func_d;
  logic                   req_live;

  ebus_prio #(.N(NREQ)) u_prio (
    .req_i    (req),
    .onehot_o (grant_d),
    .valid_o  (pick_valid)
  );

  always_comb begin
    cs_d   = '0;
    func_d = CONO;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_d[i]) begin
        cs_d   = reqCS[i*EBUS_CS_W +: EBUS_CS_W];
        func_d = tEBUSfunc'(reqFunc[i*EBUS_FUNC_W +: EBUS_FUNC_W]);
      end
    end
  end

  // The owning master must keep requesting until done, otherwise the cycle aborts.
  assign req_live = |(req & grant_q);

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rd_q      <= '0;
      cs_q      <= '0;
      func_q    <= CONO;
      demand_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      if (done_q) grant_q <= '0;
      case (state_q)
        IDLE: begin
          // Holding off while done is high leaves one idle cycle between owners.
          if (!done_q && pick_valid) begin
            grant_q <= grant_d;
            cs_q    <= cs_d;
            func_q  <= func_d;
            cnt_q   <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (!req_live) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else if (cnt_q == SETUP_LAST) begin
            demand_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= DEMAND;
          end else begin
            cnt_q <= cnt_q + EBUS_CNT_W'(1);
          end
        end
        DEMAND: begin
          if (!req_live) begin
            grant_q  <= '0;
            demand_q <= 1'b0;
            state_q  <= IDLE;
          end else if (ebusXfer) begin
            if (is_read_func(func_q)) rd_q <= ebusData;
            demand_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= XWAIT;
          end else if (cnt_q == TO_LAST) begin
            rd_q      <= '0;
            demand_q  <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + EBUS_CNT_W'(1);
          end
        end
        XWAIT: begin
          if (!ebusXfer) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign rdData     = rd_q;
  assign busy       = (state_q != IDLE);
  assign ebusCS     = cs_q;
  assign ebusFunc   = func_q;
  assign ebusDemand = demand_q;

`ifdef EBUS_CONFLICT_CHECK_EN
  logic multi_drv;
  logic multi_q;
  logic conflict_q;

  assign multi_drv = |(drivers & (drivers - NDRV'(1)));

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      multi_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      multi_q <= multi_drv;
      if (multi_drv) conflict_q <= 1'b1;
      if (multi_drv && !multi_q)
        $display("%0t ebus_ctl: multiple EBUS drivers %b", $time, drivers);
    end
  end

  assign conflict = conflict_q;
`else
  logic unused_drivers;
  assign unused_drivers = ^drivers;
  assign conflict       = 1'b0;
`endif

endmodule

// File: tb/tb_ebus_ctl.sv
// Scoreboard bench for ebus_ctl: expected completions are queued at stimulus time and popped on done.
module tb_ebus_ctl;
  import ebus_ctl_pkg::*;

  logic        clk = 1'b0;
  logic        CROBAR = 1'b1;
  logic [2:0]  req = '0;
  logic [8:0]  reqFunc = '0;
  logic [20:0] reqCS = '0;
  logic [2:0]  grant;
  logic        done, timeout, busy, ebusDemand, conflict;
  logic [35:0] rdData;
  logic [6:0]  ebusCS;
  logic [2:0]  ebusFunc;
  logic        ebusXfer = 1'b0;
  logic [35:0] ebusData = '0;
  logic [12:0] drivers = '0;

  typedef struct {
    int          idx;
    logic        to;
    logic [35:0] rd;
    logic [6:0]  cs;
    logic [2:0]  func;
  } sb_t;

  sb_t         sb[$];
  sb_t         mon_e;
  logic [35:0] model_rd = '0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        exp_conf;

  ebus_ctl dut (
    .clk        (clk),
    .CROBAR     (CROBAR),
    .req        (req),
    .reqFunc    (reqFunc),
    .reqCS      (reqCS),
    .grant      (grant),
    .done       (done),
    .timeout    (timeout),
    .rdData     (rdData),
    .busy       (busy),
    .ebusCS     (ebusCS),
    .ebusFunc   (ebusFunc),
    .ebusDemand (ebusDemand),
    .ebusXfer   (ebusXfer),
    .ebusData   (ebusData),
    .drivers    (drivers),
    .conflict   (conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int k, input tEBUSfunc f, input logic [6:0] cs);
    reqFunc[k*3 +: 3] = f;
    reqCS[k*7 +: 7]   = cs;
  endtask

  // Expected completion for master k, using its currently programmed func/CS.
  task automatic expect_txn(input int k, input logic to, input logic [35:0] data);
    logic [2:0] f;
    f = reqFunc[k*3 +: 3];
    if (to) model_rd = '0;
    else if (f == 3'd1 || f == 3'd3 || f == 3'd5) model_rd = data;
    sb.push_back('{k, to, model_rd, reqCS[k*7 +: 7], f});
  endtask

  task automatic wait_demand(input string tag);
    int n;
    n = 0;
    while (!ebusDemand && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(ebusDemand), 64'(1));
  endtask

  always @(negedge clk) begin
    if (!CROBAR) begin
      check("grant_onehot", 64'($countones(grant) <= 1), 64'(1));
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(1), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          check("sb_grant", 64'(grant), 64'(1) << mon_e.idx);
          check("sb_timeout", 64'(timeout), 64'(mon_e.to));
          check("sb_rdData", 64'(rdData), 64'(mon_e.rd));
          check("sb_cs", 64'(ebusCS), 64'(mon_e.cs));
          check("sb_func", 64'(ebusFunc), 64'(mon_e.func));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] dv [3];
    int n;
`ifdef EBUS_CONFLICT_CHECK_EN
    exp_conf = 1'b1;
`else
    exp_conf = 1'b0;
`endif
    dv[0] = 36'h1_2345_6789;
    dv[1] = 36'h0_DEAD_BEEF;
    dv[2] = 36'hA_5A5A_5A5A;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_timeout", 64'(timeout), 64'(0));
    check("rst_rdData", 64'(rdData), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_cs", 64'(ebusCS), 64'(0));
    check("rst_func", 64'(ebusFunc), 64'(0));
    check("rst_demand", 64'(ebusDemand), 64'(0));
    check("rst_conflict", 64'(conflict), 64'(0));
    CROBAR = 1'b0;
    tick();

    // T1: DATAI from master 2, xfer asserted in IDLE/SETUP must be ignored
    set_master(2, DATAI, 7'o40);
    expect_txn(2, 1'b0, 36'o123456654321);
    req = 3'b100;
    ebusXfer = 1'b1;
    ebusData = 36'o000777000777;
    tick();  // cycle 1
    check("t1_grant", 64'(grant), 64'(3'b100));
    check("t1_demand_c1", 64'(ebusDemand), 64'(0));
    set_master(2, CONO, 7'o77);
    tick();  // cycle 2
    check("t1_demand_c2", 64'(ebusDemand), 64'(0));
    tick();  // cycle 3
    check("t1_demand_c3", 64'(ebusDemand), 64'(1));
    ebusXfer = 1'b0;
    tick();  // cycle 4
    tick();  // cycle 5
    check("t1_done_c5", 64'(done), 64'(0));
    ebusXfer = 1'b1;
    ebusData = 36'o123456654321;
    tick();  // cycle 6
    check("t1_done_c6", 64'(done), 64'(1));
    check("t1_demand_off", 64'(ebusDemand), 64'(0));
    ebusXfer = 1'b0;
    req = 3'b000;
    tick();
    check("t1_grant_drop", 64'(grant), 64'(0));
    check("t1_idle", 64'(busy), 64'(0));
    tick();

    // T4: CONO, xfer held high after done keeps XWAIT; waiting master granted afterwards
    set_master(1, CONO, 7'o12);
    expect_txn(1, 1'b0, 36'o0);
    req = 3'b010;
    wait_demand("t4_demand");
    ebusXfer = 1'b1;
    ebusData = 36'o777777000000;
    tick();
    check("t4_done", 64'(done), 64'(1));
    req = 3'b000;
    set_master(0, CONO, 7'o3);
    expect_txn(0, 1'b0, 36'o0);
    req = 3'b001;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_xwait_busy", 64'(busy), 64'(1));
      check("t4_xwait_nogrant", 64'(grant), 64'(0));
    end
    ebusXfer = 1'b0;
    tick();
    check("t4_idle", 64'(busy), 64'(0));
    check("t4_idle_grant", 64'(grant), 64'(0));
    tick();
    check("t4_next_grant", 64'(grant), 64'(3'b001));
    wait_demand("t4_demand2");
    ebusXfer = 1'b1;
    tick();
    ebusXfer = 1'b0;
    req = 3'b000;
    tick();
    tick();

    // T2: all three request together, served 0,1,2 with an idle cycle between
    set_master(0, CONI, 7'o1);
    set_master(1, DATAO, 7'o2);
    set_master(2, PIread, 7'o3);
    for (int k = 0; k < 3; k++) expect_txn(k, 1'b0, dv[k]);
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      wait_demand("t2_demand");
      check("t2_owner", 64'(grant), 64'(1) << k);
      ebusXfer = 1'b1;
      ebusData = dv[k];
      tick();
      check("t2_done", 64'(done), 64'(1));
      ebusXfer = 1'b0;
      req[k] = 1'b0;
      tick();
      check("t2_gap_idle", 64'(busy), 64'(0));
      if (k < 2) begin
        tick();
        check("t2_next_grant", 64'(grant), 64'(1) << (k + 1));
      end
    end
    tick();

    // T3: no response -> timeout 64 cycles after demand
    ebusData = 36'o555555555555;
    set_master(0, DATAI, 7'o5);
    expect_txn(0, 1'b1, 36'o0);
    req = 3'b001;
    wait_demand("t3_demand");
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("t3_to_latency", 64'(n), 64'(64));
    check("t3_busy_at_done", 64'(busy), 64'(0));
    check("t3_grant_held", 64'(grant), 64'(3'b001));
    req = 3'b000;
    tick();
    check("t3_grant_drop", 64'(grant), 64'(0));
    tick();

    // T3b: xfer on the same edge the timeout count is reached -> transfer wins
    set_master(1, DATAI, 7'o6);
    expect_txn(1, 1'b0, 36'o246024602460);
    req = 3'b010;
    wait_demand("t3b_demand");
    repeat (63) tick();
    ebusXfer = 1'b1;
    ebusData = 36'o246024602460;
    tick();
    check("t3b_done", 64'(done), 64'(1));
    check("t3b_no_timeout", 64'(timeout), 64'(0));
    ebusXfer = 1'b0;
    req = 3'b000;
    tick();
    tick();

    // T5a: master 1 drops req during SETUP -> abort, no done
    set_master(1, DATAI, 7'o21);
    req = 3'b010;
    tick();
    check("t5a_grant", 64'(grant), 64'(3'b010));
    req = 3'b000;
    tick();
    check("t5a_busy", 64'(busy), 64'(0));
    check("t5a_grant_drop", 64'(grant), 64'(0));
    check("t5a_demand", 64'(ebusDemand), 64'(0));
    repeat (3) tick();
    check("t5a_rd_kept", 64'(rdData), 64'(model_rd));

    // T5b: CROBAR during DEMAND clears outputs asynchronously
    set_master(2, DATAI, 7'o11);
    req = 3'b100;
    wait_demand("t5b_demand");
    #2;
    CROBAR = 1'b1;
    #1;
    check("t5b_grant", 64'(grant), 64'(0));
    check("t5b_done", 64'(done), 64'(0));
    check("t5b_rdData", 64'(rdData), 64'(0));
    check("t5b_busy", 64'(busy), 64'(0));
    check("t5b_cs", 64'(ebusCS), 64'(0));
    check("t5b_func", 64'(ebusFunc), 64'(0));
    check("t5b_demand", 64'(ebusDemand), 64'(0));
    req = 3'b000;
    model_rd = '0;
    tick();
    CROBAR = 1'b0;
    tick();
    check("t5b_after_busy", 64'(busy), 64'(0));

    // T6: two drivers for one cycle
    drivers = 13'b0000000000101;
    tick();
    drivers = '0;
    tick();
    check("t6_conflict", 64'(conflict), 64'(exp_conf));
    repeat (3) tick();
    check("t6_conflict_sticky", 64'(conflict), 64'(exp_conf));
    CROBAR = 1'b1;
    #1;
    check("t6_conflict_rst", 64'(conflict), 64'(0));
    tick();
    CROBAR = 1'b0;
    tick();

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ebus_ctl.md
Name: ebus_ctl

Overview:
Arbitrates and sequences the shared EBUS between multiple masters: PI, DTE and the EBOX I/O-instruction path.
- Grants one master at a time.
- Drives the CS (device select) and function lines.
- Runs the demand/transfer handshake with the selected device, with a timeout.
- Captures read data.
It sits beside the top-level EBUS data mux and decides when each master's transaction owns the bus.

Parameters:
NREQ, 3, number of bus masters; index 0 has highest priority.
SETUP_CYC, 2, cycles CS/func are held stable before demand asserts (1..15).
TIMEOUT_CYC, 64, demand cycles without transfer before timeout (2..1023).
NDRV, 13, number of EBUS data driver-enable inputs monitored.

Ports:
clk  in  1  system clock, rising edge.
CROBAR  in  1  asynchronous reset, active-high.
req  in  NREQ  per-master request level.
reqFunc  in  NREQ*3  per-master function (tEBUSfunc).
reqCS  in  NREQ*7  per-master device code.
grant  out  NREQ  one-hot grant.
done  out  1  one-cycle completion pulse to the granted master.
timeout  out  1  valid with done; transfer timed out.
rdData  out  36  captured EBUS data for read functions.
busy  out  1  state != IDLE.
ebusCS  out  7  device select to EBUS.
ebusFunc  out  3  function to EBUS.
ebusDemand  out  1  demand to devices.
ebusXfer  in  1  device transfer acknowledge (synchronous to clk).
ebusData  in  36  muxed EBUS data.
drivers  in  NDRV  EBUS driver-enable flags from all modules.
conflict  out  1  sticky multiple-driver error.

Behaviour:
- Reset, asynchronous, while CROBAR=1: state=IDLE, all counters 0, and every output 0 (grant, done, timeout, rdData, busy, ebusCS, ebusFunc, ebusDemand, conflict).
- IDLE:
  - If any req is set, latch the lowest asserted index i.
  - Next cycle: grant[i]=1, ebusCS/ebusFunc = master i's values (registered), state SETUP, counter=0.
- SETUP:
  - Counter increments each cycle.
  - After SETUP_CYC cycles: ebusDemand=1, state DEMAND, counter cleared.
- DEMAND:
  - On ebusXfer=1: if func is CONI, DATAI or PI-read, rdData<=ebusData; otherwise rdData is unchanged.
  - In the same edge: ebusDemand=0, done=1 for one cycle, state XWAIT.
  - If counter reaches TIMEOUT_CYC-1 with no xfer: done=1, timeout=1, rdData<=0, ebusDemand=0, state IDLE.
- XWAIT:
  - Wait for ebusXfer=0, then go to IDLE.
  - grant drops on the cycle after done in both the normal and timeout paths.
- Latency: no-wait device, req to done = 1 + SETUP_CYC + 1 cycles (4 at defaults).
- Abort: if req[i] deasserts while granted and before done, go to IDLE next cycle with ebusDemand=0, no done, rdData unchanged.
- Higher-priority req arriving while busy is ignored until IDLE; no preemption.
- Back-to-back: a master still requesting after done is re-arbitrated from IDLE, with one idle cycle between transactions.
- ebusXfer=1 observed in IDLE or SETUP is ignored.
- ebusXfer=1 on the same edge that the timeout count is reached: the transfer wins (timeout=0).
- reqFunc/reqCS are sampled only at grant; later changes do not propagate.

Optional Feature:
EBUS_CONFLICT_CHECK_EN
- Defined: any cycle with more than one bit of drivers set sets conflict (sticky until CROBAR), and $display prints time and the drivers vector once per rising edge of the condition.
- Undefined: conflict is tied to 0 and drivers is unused.

Decomposition:
- Shared in ebox.svh:
  - tEBUSfunc enum, 3 bits: CONO=0, CONI=1, DATAO=2, DATAI=3, PIserv=4, PIread=5, rsvd 6–7.
  - tEBUSstate enum: IDLE, SETUP, DEMAND, XWAIT.
- One natural sub-module, ebus_prio: a combinational lowest-index picker producing a one-hot and a valid bit, reused by the PI logic.

Test Plan:
- Single DATAI from master 2 (CS=7'o40); device xfer 3 cycles after demand with ebusData=36'o123456_654321 -> grant[2] from cycle 1, demand at cycle 3, done at cycle 6, rdData=36'o123456654321, timeout=0.
- req=3'b111 simultaneously -> serviced in order 0, 1, 2; each grant one-hot; never more than one grant asserted.
- No device response -> done and timeout pulse exactly TIMEOUT_CYC cycles after demand (64), rdData=0, returns to IDLE.
- CONO with xfer held high for 5 cycles after done -> state stays XWAIT until xfer falls; a new req is granted only afterwards; rdData is unchanged from before.
- Master 1 drops req during SETUP; separately, CROBAR asserted in DEMAND -> abort with no done; reset clears all outputs immediately (asynchronously).
- With EBUS_CONFLICT_CHECK_EN defined, drivers=13'b0000000000101 for one cycle -> conflict=1 and stays 1 until CROBAR; without the macro, conflict remains 0.
